tage_uclear_sched: RTL and testbench

Write-port scheduler for one TAGE useful-bit (u) bank. It shares the bank's single write port between two requesters:
- commit-side u updates from the TAGE update path;
- a background sweeper that clears every u entry to zero, row by row, when the global reset-u counter saturates.

This replaces a one-cycle synchronous clear of the whole RAM. One instance sits per bank/slot, between the TAGE update logic and the u MPRAM write port.

---
 rtl/tage_uclear_sched_pkg.sv | 13 +
 rtl/tage_uclear_sched_if.sv | 28 ++
 rtl/tage_uclear_sched.sv | 102 ++++++++++
 tb/tb_tage_uclear_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tage_uclear_sched_pkg.sv
// rtl/tage_uclear_sched_pkg.sv - shared TAGE u-bank definitions for the clear scheduler
package tage_uclear_sched_pkg;

  localparam int TAGE_U_SIZE     = 2;
  // Width of the global reset-u counter that produces reset_req (used by the instantiating logic).
  localparam int TAGE_RESETU_CTR = 19;

  typedef enum logic {
    UC_IDLE  = 1'b0,
    UC_SWEEP = 1'b1
  } uclear_state_t;

endpackage

// File: rtl/tage_uclear_sched_if.sv
// rtl/tage_uclear_sched_if.sv - request/update and u RAM write-port bundle for the clear scheduler
interface tage_uclear_sched_if #(
  parameter int ADDR_W = 10,
  parameter int U_W    = 2
);

  logic              reset_req;
  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_idx;
  logic [U_W-1:0]    upd_u;
  logic              port_we;
  logic [ADDR_W-1:0] port_waddr;
  logic [U_W-1:0]    port_wdata;
  logic              sweep_busy;
  logic              sweep_done;

  modport master (
    output reset_req, upd_valid, upd_idx, upd_u,
    input  upd_ready, port_we, port_waddr, port_wdata, sweep_busy, sweep_done
  );

  modport slave (
    input  reset_req, upd_valid, upd_idx, upd_u,
    output upd_ready, port_we, port_waddr, port_wdata, sweep_busy, sweep_done
  );

endinterface

// File: rtl/tage_uclear_sched.sv
// rtl/tage_uclear_sched.sv - shares one u-bank write port between commit updates and a row-by-row clear sweep
module tage_uclear_sched
  import tage_uclear_sched_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int U_W       = TAGE_U_SIZE,
  parameter int MAX_DEFER = 8
) (
  input  logic clk,
  input  logic rst,
  tage_uclear_sched_if.slave bus
);

  localparam int                 DEFER_W   = $clog2(MAX_DEFER + 1);
  localparam logic [ADDR_W-1:0]  LAST_ROW  = ADDR_W'(DEPTH - 1);
  localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(MAX_DEFER);

  uclear_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  sweep_ptr_q, sweep_ptr_d;
  logic [DEFER_W-1:0] defer_cnt_q, defer_cnt_d;
  logic               pending_q, pending_d;
  logic               done_q, done_d;
  logic               sweep_slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= UC_IDLE;
      sweep_ptr_q <= '0;
      defer_cnt_q <= '0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      defer_cnt_q <= defer_cnt_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
    end
  end

  // The sweeper takes the port when nobody else wants it, or after losing MAX_DEFER times in a row.
  assign sweep_slot = ~bus.upd_valid | (defer_cnt_q == DEFER_MAX);

  always_comb begin
    state_d        = state_q;
    sweep_ptr_d    = sweep_ptr_q;
    defer_cnt_d    = defer_cnt_q;
    pending_d      = pending_q;
    done_d         = 1'b0;
    bus.upd_ready  = 1'b1;
    bus.port_we    = bus.upd_valid;
    bus.port_waddr = bus.upd_idx;
    bus.port_wdata = bus.upd_u;
    bus.sweep_busy = 1'b0;

    case (state_q)
      UC_IDLE: begin
        if (bus.reset_req) begin
          state_d     = UC_SWEEP;
          sweep_ptr_d = '0;
          defer_cnt_d = '0;
          pending_d   = 1'b0;
        end
      end

      UC_SWEEP: begin
        bus.sweep_busy = 1'b1;
        if (bus.reset_req) pending_d = 1'b1;
        if (sweep_slot) begin
          bus.port_we    = 1'b1;
          bus.port_waddr = sweep_ptr_q;
          bus.port_wdata = '0;
          bus.upd_ready  = 1'b0;
          defer_cnt_d    = '0;
          if (sweep_ptr_q == LAST_ROW) begin
            done_d      = 1'b1;
            sweep_ptr_d = '0;
            // A request arriving with the final write still earns a fresh sweep; all requests collapse to one.
            if (pending_q | bus.reset_req) pending_d = 1'b0;
            else                           state_d   = UC_IDLE;
          end else begin
            sweep_ptr_d = sweep_ptr_q + 1'b1;
          end
        end else begin
          defer_cnt_d = defer_cnt_q + 1'b1;
        end
      end

      default: state_d = UC_IDLE;
    endcase

    if (rst) begin
      bus.port_we    = 1'b0;
      bus.upd_ready  = 1'b1;
      bus.sweep_busy = 1'b0;
    end
  end

  assign bus.sweep_done = done_q;

endmodule

// File: tb/tb_tage_uclear_sched.sv
// tb/tb_tage_uclear_sched.sv - directed and randomized checks of the u-bank clear scheduler against a behavioural model
module tb_tage_uclear_sched;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int UW    = 2;
  localparam int MD    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tage_uclear_sched_if #(.ADDR_W(AW), .U_W(UW)) tif ();

  tage_uclear_sched #(.DEPTH(DEPTH), .ADDR_W(AW), .U_W(UW), .MAX_DEFER(MD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a sweep is "which row is next, how many times it has been skipped, and whether another is owed".
  int m_sweep = 0, m_row = 0, m_skips = 0, m_owed = 0, m_done = 0;

  always @(negedge clk) begin
    int  e_we, e_ready, e_busy, e_done, e_addr, e_data;
    bit  sweeper_turn;
    e_addr = 0;
    e_data = 0;
    if (rst) begin
      e_we = 0; e_ready = 1; e_busy = 0; e_done = 0;
      m_sweep = 0; m_row = 0; m_skips = 0; m_owed = 0; m_done = 0;
    end else begin
      e_done = m_done;
      m_done = 0;
      if (m_sweep == 0) begin
        e_busy = 0; e_ready = 1; e_we = int'(tif.upd_valid);
        e_addr = int'(tif.upd_idx); e_data = int'(tif.upd_u);
        if (tif.reset_req) begin
          m_sweep = 1; m_row = 0; m_skips = 0; m_owed = 0;
        end
      end else begin
        e_busy = 1;
        sweeper_turn = !tif.upd_valid || (m_skips >= MD);
        if (sweeper_turn) begin
          e_we = 1; e_ready = 0; e_addr = m_row; e_data = 0;
          m_skips = 0;
          if (m_row == DEPTH - 1) begin
            m_done = 1;
            m_row  = 0;
            if (m_owed != 0 || tif.reset_req) m_owed = 0;
            else m_sweep = 0;
          end else begin
            m_row = m_row + 1;
            if (tif.reset_req) m_owed = 1;
          end
        end else begin
          e_we = 1; e_ready = 1;
          e_addr = int'(tif.upd_idx); e_data = int'(tif.upd_u);
          m_skips = m_skips + 1;
          if (tif.reset_req) m_owed = 1;
        end
      end
    end
    chk("cmp_port_we", int'(tif.port_we), e_we);
    chk("cmp_upd_ready", int'(tif.upd_ready), e_ready);
    chk("cmp_sweep_busy", int'(tif.sweep_busy), e_busy);
    chk("cmp_sweep_done", int'(tif.sweep_done), e_done);
    if (e_we != 0) begin
      chk("cmp_port_waddr", int'(tif.port_waddr), e_addr);
      chk("cmp_port_wdata", int'(tif.port_wdata), e_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    #3;
  endtask

  initial begin
    int done_at, nwr, cur, first_stall, acc, nd, nbusy;
    bit hold;

    tif.reset_req = 1'b0;
    tif.upd_valid = 1'b1;
    tif.upd_idx   = '0;
    tif.upd_u     = '0;
    #2;
    chk("rst_port_we", int'(tif.port_we), 0);
    chk("rst_upd_ready", int'(tif.upd_ready), 1);
    chk("rst_sweep_busy", int'(tif.sweep_busy), 0);
    chk("rst_sweep_done", int'(tif.sweep_done), 0);
    tif.upd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle pass-through
    tif.upd_valid = 1'b1; tif.upd_idx = 4'h5; tif.upd_u = 2'd2;
    samp();
    chk("idle_we", int'(tif.port_we), 1);
    chk("idle_waddr", int'(tif.port_waddr), 5);
    chk("idle_wdata", int'(tif.port_wdata), 2);
    chk("idle_ready", int'(tif.upd_ready), 1);
    tick();
    tif.upd_valid = 1'b0;

    // Clean sweep, no updates
    tif.reset_req = 1'b1;
    samp(); tick();
    tif.reset_req = 1'b0;
    done_at = -1; nwr = 0;
    for (int k = 1; k <= 30; k++) begin
      samp();
      if (tif.port_we) begin
        nwr++;
        chk("clean_waddr", int'(tif.port_waddr), k - 1);
      end
      if (tif.sweep_done && done_at < 0) begin
        done_at = k;
        chk("clean_busy_at_done", int'(tif.sweep_busy), 0);
      end
      tick();
    end
    chk("clean_writes", nwr, 16);
    chk("clean_done_cycle", done_at, 17);

    // Starvation guard with continuous updates; acceptance order proves no lost or duplicated update
    cur = 0;
    tif.upd_valid = 1'b1; tif.upd_idx = AW'(cur); tif.upd_u = UW'(cur);
    tif.reset_req = 1'b1;
    samp();
    if (tif.upd_ready) cur++;
    tick();
    tif.reset_req = 1'b0;
    first_stall = -1; acc = 0; done_at = -1;
    for (int k = 1; k <= 160; k++) begin
      tif.upd_idx = AW'(cur); tif.upd_u = UW'(cur);
      samp();
      if (k == 10) chk("starve_held_accept", int'(tif.port_waddr), 9);
      if (tif.upd_ready) begin
        chk("starve_upd_addr", int'(tif.port_waddr), cur % 16);
        if (k <= 144) acc++;
        cur++;
      end else if (first_stall < 0) begin
        first_stall = k;
        chk("starve_first_sweep_row", int'(tif.port_waddr), 0);
      end
      if (tif.sweep_done && done_at < 0) done_at = k;
      tick();
    end
    tif.upd_valid = 1'b0;
    chk("starve_first_stall", first_stall, 9);
    chk("starve_accepted", acc, 128);
    chk("starve_done_cycle", done_at, 145);

    // Queued restart: requests on row 7 and on the final row yield exactly one extra sweep
    tif.reset_req = 1'b1;
    samp(); tick();
    nd = 0; nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      tif.reset_req = (k == 8 || k == 16);
      samp();
      if (k == 8)  chk("queue_row7", int'(tif.port_waddr), 7);
      if (k == 16) chk("queue_row15", int'(tif.port_waddr), 15);
      if (tif.sweep_done) begin
        nd++;
        if (nd == 1) chk("queue_done1_cycle", k, 17);
        else         chk("queue_done2_cycle", k, 33);
      end
      if (tif.sweep_busy) nbusy++;
      tick();
    end
    tif.reset_req = 1'b0;
    chk("queue_done_count", nd, 2);
    chk("queue_busy_cycles", nbusy, 32);

    // Async reset while row 10 is being written
    tif.reset_req = 1'b1;
    samp(); tick();
    tif.reset_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      samp(); tick();
    end
    samp();
    chk("abort_row10", int'(tif.port_waddr), 10);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_we", int'(tif.port_we), 0);
    chk("abort_busy", int'(tif.sweep_busy), 0);
    tick(); tick();
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      samp();
      if (tif.sweep_done) nd++;
      tick();
    end
    chk("abort_no_done", nd, 0);
    tif.upd_valid = 1'b1; tif.upd_idx = 4'h7; tif.upd_u = 2'd3;
    samp();
    chk("abort_pass_we", int'(tif.port_we), 1);
    chk("abort_pass_waddr", int'(tif.port_waddr), 7);
    chk("abort_pass_wdata", int'(tif.port_wdata), 3);
    tick();

    // Randomized traffic; a stalled update is held until accepted
    hold = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      if (!hold) begin
        tif.upd_valid = ($urandom_range(0, 3) != 0);
        tif.upd_idx   = AW'($urandom);
        tif.upd_u     = UW'($urandom);
      end
      tif.reset_req = ($urandom_range(0, 39) == 0);
      rst           = ($urandom_range(0, 799) == 0);
      samp();
      hold = tif.upd_valid && !tif.upd_ready && !rst;
      tick();
    end
    rst = 1'b0;
    tif.reset_req = 1'b0;
    tif.upd_valid = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
